// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the scalar RV32I multi-cycle core.
//               Provides the sequencer state encoding so fetch, decode, ALU,
//               memory and writeback logic all decode the same state bus
//               instead of using literal state numbers.
// Contents    : state_t  - 3-bit sequencer state enum
//               STATE_W  - width of the state bus
//               is_exec_state() - true for states that count as executing
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int STATE_W = 3;

    // Code 7 is deliberately unused; the sequencer recovers from it.
    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // FETCH..WRITE are the states in which the core is doing useful work.
    function automatic logic is_exec_state(input state_t s);
        return (s <= WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : perf_counters
// Description : Cycle and retired-instruction counters for the core.
//               Both counters wrap modulo 2^CNT_W.
// Ports       : clk          - clock
//               rst          - synchronous active-high reset, clears counters
//               inc_cycle    - count one executing cycle
//               inc_instret  - count one retired instruction
//               cycle_cnt    - executing-cycle count
//               instret_cnt  - retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counters #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_cycle,
    input  logic             inc_instret,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (inc_cycle) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (inc_instret) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control FSM for the scalar RV32I core. Drives the
//               shared state bus, sequences the instruction-memory, data-memory
//               and output-port handshakes, pulses register-file and PC write
//               enables, and traps to ERROR on a memory wait-state timeout.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               imem_ready, dmem_ready   - memory handshake completions
//               out_ready                - output port accepts data
//               mem_read, mem_write      - decoded load/store flags (EXEC on)
//               reg_write, data_out      - decoded rf-write / output flags
//               halt_req                 - external halt request
//               state                    - current sequencer state
//               imem_req, dmem_req       - memory requests
//               instr_we                 - latch fetched instruction
//               out_valid                - output data valid
//               rf_we, pc_we             - writeback strobes
//               cycle_cnt, instret_cnt   - performance counters
//               timeout                  - sticky wait-state timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024,
    parameter int CNT_W       = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               out_ready,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               reg_write,
    input  logic               data_out,
    input  logic               halt_req,
    output logic [STATE_W-1:0] state,
    output logic               imem_req,
    output logic               instr_we,
    output logic               dmem_req,
    output logic               out_valid,
    output logic               rf_we,
    output logic               pc_we,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt,
    output logic               timeout
);

    // A zero limit disables the timeout but still needs a 1-bit counter.
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic              C_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;

    logic [WAIT_W-1:0] w_wait_next;
    logic              w_wait_expired;

    assign w_wait_next    = r_wait_cnt + 1'b1;
    // This wait cycle is the MEM_TIMEOUT-th without ready; a ready seen in
    // the same cycle is checked first and wins.
    assign w_wait_expired = C_TIMEOUT_EN && (w_wait_next == C_WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            // Every state change clears the wait counter; the waiting
            // branches below override this while they stay put.
            r_wait_cnt <= '0;
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_state <= DECODE;
                    end else if (w_wait_expired) begin
                        r_state   <= ERROR;
                        r_timeout <= 1'b1;
                    end else if (C_TIMEOUT_EN) begin
                        r_wait_cnt <= w_wait_next;
                    end
                end
                DECODE: begin
                    r_state <= EXEC;
                end
                EXEC: begin
                    // Output instructions hold here with no timeout.
                    if (!data_out || out_ready) begin
                        r_state <= (mem_read || mem_write) ? MEM : WRITE;
                    end
                end
                MEM: begin
                    if (dmem_ready) begin
                        r_state <= WRITE;
                    end else if (w_wait_expired) begin
                        r_state   <= ERROR;
                        r_timeout <= 1'b1;
                    end else if (C_TIMEOUT_EN) begin
                        r_wait_cnt <= w_wait_next;
                    end
                end
                WRITE: begin
                    // Halt is sampled only here so the instruction retires.
                    r_state <= halt_req ? HALT : FETCH;
                end
                HALT: begin
                    if (!halt_req) begin
                        r_state <= FETCH;
                    end
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // Strobes are gated by rst so outstanding requests drop immediately.
    assign imem_req  = !rst && (r_state == FETCH);
    assign instr_we  = !rst && (r_state == FETCH) && imem_ready;
    assign dmem_req  = !rst && (r_state == MEM);
    assign out_valid = !rst && (r_state == EXEC) && data_out;
    assign rf_we     = !rst && (r_state == WRITE) && reg_write;
    assign pc_we     = !rst && (r_state == WRITE);

    assign state   = r_state;
    assign timeout = r_timeout;

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk         (clk),
        .rst         (rst),
        .inc_cycle   (!rst && is_exec_state(r_state)),
        .inc_instret (!rst && (r_state == WRITE)),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule
`default_nettype wire
